swivm_tick_irq: RTL and testbench
=================================

// Module: swivm_tick_irq
// PURPOSE
//  CPU-side consumer of the periodic clock-tick pulse (one pulse per 2^16 clk). Detects each
//  tick, queues it in a saturating pending counter and presents a level interrupt to the SwiVM
//  core with an ack/EOI handshake. Also keeps a free-running uptime count of ticks. Sits between
//  the tick source and the core's interrupt input.
// PARAMETERS
//  PEND_W    4   width of pending-tick counter; saturates at 2^PEND_W-1
//  UPTIME_W  32  width of uptime tick counter; wraps modulo 2^UPTIME_W
// PORTS
//  clk         in   1         system clock; all state on rising edge
//  reset       in   1         asynchronous, active-high reset
//  tick        in   1         tick from timebase; may stay high >1 cycle; one rising edge = one tick
//  ien_wr      in   1         1-cycle strobe: load ien from ien_data, clear overrun
//  ien_data    in   1         interrupt enable value for ien_wr
//  irq_ack     in   1         1-cycle pulse from core: interrupt taken
//  irq_eoi     in   1         1-cycle pulse from core: end of service routine
//  irq         out  1         interrupt request level to core
//  ien         out  1         current interrupt enable
//  in_service  out  1         high from accepted ack until eoi
//  pending     out  PEND_W    queued unserviced ticks
//  overrun     out  1         sticky: tick arrived while pending saturated
//  uptime      out  UPTIME_W  total ticks detected since reset
// BEHAVIOUR
//  Reset (async, any time incl. mid-service): state=IDLE, irq=0, ien=0, in_service=0, pending=0,
//   overrun=0, uptime=0, tick history reg=0 (tick high during/after reset release counts once).
//  Edge detect: tick_q <= tick; tick_rise = tick & ~tick_q. tick_rise visible in pending/uptime
//   one cycle after the rising edge is sampled (latency 1 clk); irq follows same edge if ien=1.
//  uptime: +1 per tick_rise, wraps to 0 from all-ones, unaffected by ien.
//  pending: +1 on tick_rise, -1 on accepted ack; both same cycle -> unchanged. At max with
//   tick_rise and no accepted ack -> stays max, overrun<=1. overrun cleared only by ien_wr/reset.
//  FSM states (encodings in shared header):
//   IDLE       pending==0, not in service. tick_rise -> PENDING.
//   PENDING    pending>0. irq = ien. irq_ack & ien -> IN_SERVICE (pending-1, in_service=1).
//              irq_ack while ien=0 is ignored.
//   IN_SERVICE irq=0 regardless of pending. irq_eoi -> PENDING if pending(next)>0 else IDLE.
//              tick_rise still counts. irq_ack here ignored.
//  irq_eoi outside IN_SERVICE ignored. irq_ack and irq_eoi same cycle: ack evaluated in current
//   state only (PENDING: ack wins, eoi ignored; IN_SERVICE: eoi wins, ack ignored).
//  irq is registered (no combinational path from inputs). ien_wr same cycle as irq_ack: ack uses
//   old ien. Clearing ien drops irq next cycle; pending is preserved.
//  ien_wr sets ien<=ien_data next cycle and clears overrun (a same-cycle saturating tick still
//   wins: overrun=1).
// STRUCTURE
//  Shared header swivm_defs.v: FSM state localparams (IDLE/PENDING/IN_SERVICE), default widths.
//  One sub-module: swivm_edge_detect (clk, reset, in -> rise pulse), reusable for other strobes.
//  Top holds FSM, pending/uptime counters, ien and overrun flags.
// TESTING
//  1 reset, ien_wr=1 data=1, one tick high 1 clk -> next clk pending=1, uptime=1, irq=1.
//  2 tick held high 5 clks -> uptime +1 only; ack -> irq=0, in_service=1, pending=0; eoi -> IDLE.
//  3 ien=1, 3 ticks before ack -> pending=3; ack,eoi x3 -> irq re-asserts after each eoi, ends 0.
//  4 PEND_W=4, ien=0, 16 ticks -> pending=15, overrun=1, irq=0; ien_wr data=1 -> overrun=0, irq=1.
//  5 pending=2 in PENDING: tick_rise and ack same cycle -> pending stays 2, state IN_SERVICE.
//  6 reset asserted mid IN_SERVICE with pending=4 -> all outputs 0 immediately (async), uptime=0.

Source files
------------

// File: rtl/swivm_tick_irq_pkg.sv
// Shared definitions for the SwiVM tick interrupt block: FSM state encodings and default widths.
package swivm_tick_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PENDING    = 2'd1,
        ST_IN_SERVICE = 2'd2
    } state_t;

    localparam int PEND_W_DEF   = 4;
    localparam int UPTIME_W_DEF = 32;

endpackage

// File: rtl/swivm_edge_detect.sv
// Rising-edge detector: one-cycle pulse per low-to-high transition of a level input.
module swivm_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic in_q;
    logic in_d;

    always_comb begin
        in_d = in;
        rise = in & ~in_q;
    end

    // History clears on reset so an input already high at release counts once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) in_q <= 1'b0;
        else       in_q <= in_d;
    end

endmodule

// File: rtl/swivm_tick_irq.sv
// Tick consumer: queues timebase ticks in a saturating pending count and raises a level
// interrupt with ack/EOI handshake; also counts total ticks since reset.
//
// state         | meaning
// ST_IDLE       | nothing pending, not in service
// ST_PENDING    | ticks queued, irq follows ien
// ST_IN_SERVICE | handler running, irq held low until eoi
module swivm_tick_irq
    import swivm_tick_irq_pkg::*;
#(
    parameter int PEND_W   = PEND_W_DEF,
    parameter int UPTIME_W = UPTIME_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                ien_wr,
    input  logic                ien_data,
    input  logic                irq_ack,
    input  logic                irq_eoi,
    output logic                irq,
    output logic                ien,
    output logic                in_service,
    output logic [PEND_W-1:0]   pending,
    output logic                overrun,
    output logic [UPTIME_W-1:0] uptime
);

    localparam logic [PEND_W-1:0]   PEND_MAX = '1;
    localparam logic [PEND_W-1:0]   PEND_ONE = PEND_W'(1);
    localparam logic [UPTIME_W-1:0] UP_ONE   = UPTIME_W'(1);

    state_t              state_q, state_d;
    logic                irq_q, irq_d;
    logic                ien_q, ien_d;
    logic                in_service_q, in_service_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic [UPTIME_W-1:0] uptime_q, uptime_d;

    logic tick_rise;
    logic ack_ok;
    logic pend_sat;

    swivm_edge_detect u_tick_edge (
        .clk   (clk),
        .reset (reset),
        .in    (tick),
        .rise  (tick_rise)
    );

    always_comb begin
        // Ack is judged against the ien value before any same-cycle write.
        ack_ok   = (state_q == ST_PENDING) && irq_ack && ien_q;
        pend_sat = tick_rise && !ack_ok && (pending_q == PEND_MAX);

        pending_d = pending_q;
        if (tick_rise && !ack_ok && !pend_sat) pending_d = pending_q + PEND_ONE;
        else if (!tick_rise && ack_ok)         pending_d = pending_q - PEND_ONE;

        uptime_d = uptime_q;
        if (tick_rise) uptime_d = uptime_q + UP_ONE;

        ien_d = ien_wr ? ien_data : ien_q;

        overrun_d = overrun_q;
        if (ien_wr)   overrun_d = 1'b0;
        if (pend_sat) overrun_d = 1'b1;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (tick_rise) state_d = ST_PENDING;
            ST_PENDING:    if (ack_ok)    state_d = ST_IN_SERVICE;
            ST_IN_SERVICE: if (irq_eoi)   state_d = (pending_d != '0) ? ST_PENDING : ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase

        // Outputs are computed from next-cycle values so they register without extra lag.
        irq_d        = (state_d == ST_PENDING) && ien_d;
        in_service_d = (state_d == ST_IN_SERVICE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            ien_q        <= 1'b0;
            in_service_q <= 1'b0;
            pending_q    <= '0;
            overrun_q    <= 1'b0;
            uptime_q     <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            ien_q        <= ien_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            uptime_q     <= uptime_d;
        end
    end

    assign irq        = irq_q;
    assign ien        = ien_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;
    assign uptime     = uptime_q;

endmodule

// File: tb/tb_swivm_tick_irq.sv
// Bench for swivm_tick_irq: directed scenarios plus random traffic against a count-based model.
module tb_swivm_tick_irq;

    localparam int PMAX = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick, ien_wr, ien_data, irq_ack, irq_eoi;
    logic        irq, ien, in_service, overrun;
    logic [3:0]  pending;
    logic [31:0] uptime;

    int n_chk = 0;
    int n_err = 0;

    int          m_pend;
    logic [31:0] m_up;
    bit          m_ien, m_ovr, m_svc, m_tprev;

    swivm_tick_irq #(.PEND_W(4), .UPTIME_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .ien_wr     (ien_wr),
        .ien_data   (ien_data),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .irq        (irq),
        .ien        (ien),
        .in_service (in_service),
        .pending    (pending),
        .overrun    (overrun),
        .uptime     (uptime)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_up = 0; m_ien = 0; m_ovr = 0; m_svc = 0; m_tprev = 0;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".irq"},        32'(irq),        32'(m_ien && !m_svc && m_pend > 0));
        chk({ctx, ".ien"},        32'(ien),        32'(m_ien));
        chk({ctx, ".in_service"}, 32'(in_service), 32'(m_svc));
        chk({ctx, ".pending"},    32'(pending),    32'(m_pend));
        chk({ctx, ".overrun"},    32'(overrun),    32'(m_ovr));
        chk({ctx, ".uptime"},     uptime,          m_up);
    endtask

    // Apply one cycle of inputs at negedge, advance the model, check after the next edge.
    task automatic step(input string ctx, input bit t, input bit w, input bit d,
                        input bit a, input bit e);
        bit rise, acc, sat;
        tick = t; ien_wr = w; ien_data = d; irq_ack = a; irq_eoi = e;
        rise = t && !m_tprev;
        m_tprev = t;
        acc = a && !m_svc && m_pend > 0 && m_ien;
        sat = 0;
        if (rise) m_up = m_up + 1;
        if (rise && !acc) begin
            if (m_pend == PMAX) sat = 1;
            else m_pend++;
        end else if (!rise && acc) begin
            m_pend--;
        end
        if (m_svc && e) m_svc = 0;
        else if (acc) m_svc = 1;
        if (w) begin m_ovr = 0; m_ien = d; end
        if (sat) m_ovr = 1;
        @(posedge clk);
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic idle(input string ctx);
        step(ctx, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string ctx);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(ctx);
        @(negedge clk);
        tick = 0; ien_wr = 0; ien_data = 0; irq_ack = 0; irq_eoi = 0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick = 0; ien_wr = 0; ien_data = 0; irq_ack = 0; irq_eoi = 0;
        model_reset();
        @(negedge clk);
        do_reset("rst0");

        // 1: enable, single tick
        step("s1_ien", 0, 1, 1, 0, 0);
        step("s1_tick", 1, 0, 0, 0, 0);
        chk("s1_pending1", 32'(pending), 32'd1);
        chk("s1_irq1", 32'(irq), 32'd1);
        idle("s1_low");

        // 2: held tick counts once, then ack/eoi
        for (int i = 0; i < 5; i++) step("s2_hold", 1, 0, 0, 0, 0);
        chk("s2_uptime2", uptime, 32'd2);
        step("s2_ack", 0, 0, 0, 1, 0);
        step("s2_ack2", 0, 0, 0, 1, 0);
        chk("s2_insvc", 32'(in_service), 32'd1);
        step("s2_eoi", 0, 0, 0, 0, 1);
        chk("s2_irq_after", 32'(irq), 32'd1);
        step("s2_ack3", 0, 0, 0, 1, 0);
        step("s2_eoi2", 0, 0, 0, 0, 1);
        chk("s2_idle_pend", 32'(pending), 32'd0);

        // 3: three ticks queued, drained one ack/eoi at a time
        for (int i = 0; i < 3; i++) begin
            step("s3_tick", 1, 0, 0, 0, 0);
            idle("s3_low");
        end
        chk("s3_pending3", 32'(pending), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step("s3_ack", 0, 0, 0, 1, 0);
            step("s3_eoi", 0, 0, 0, 0, 1);
        end
        chk("s3_irq_end", 32'(irq), 32'd0);

        // 4: saturation with irq disabled, ien_wr clears overrun
        step("s4_dis", 0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step("s4_tick", 1, 0, 0, 0, 0);
            idle("s4_low");
        end
        chk("s4_pend_max", 32'(pending), 32'd15);
        chk("s4_overrun", 32'(overrun), 32'd1);
        step("s4_ack_ign", 0, 0, 0, 1, 0);
        step("s4_en", 0, 1, 1, 0, 0);
        chk("s4_ovr_clr", 32'(overrun), 32'd0);
        chk("s4_irq_on", 32'(irq), 32'd1);
        step("s4_satwr", 1, 1, 1, 0, 0);
        chk("s4_sat_wins", 32'(overrun), 32'd1);
        idle("s4_low2");

        // 5: tick and ack in the same cycle with pending=2
        do_reset("rst5");
        step("s5_en", 0, 1, 1, 0, 0);
        step("s5_t1", 1, 0, 0, 0, 0);
        idle("s5_l1");
        step("s5_t2", 1, 0, 0, 0, 0);
        idle("s5_l2");
        step("s5_both", 1, 0, 0, 1, 0);
        chk("s5_pend2", 32'(pending), 32'd2);
        chk("s5_insvc", 32'(in_service), 32'd1);
        step("s5_eoi_ack", 0, 0, 0, 1, 1);
        step("s5_ack_eoi", 0, 0, 0, 1, 1);
        chk("s5_ack_wins", 32'(in_service), 32'd1);

        // 6: async reset mid-service
        do_reset("rst6a");
        step("s6_en", 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("s6_tick", 1, 0, 0, 0, 0);
            idle("s6_low");
        end
        step("s6_ack", 0, 0, 0, 1, 0);
        chk("s6_pend4", 32'(pending), 32'd4);
        #2;
        do_reset("rst6");
        chk("s6_uptime0", uptime, 32'd0);

        // tick high through reset release counts once
        tick = 1;
        step("s7_hi", 1, 0, 0, 0, 0);
        chk("s7_once", uptime, 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit t, w, d, a, e;
            t = ($urandom_range(0, 2) == 0) ? !m_tprev : m_tprev;
            w = ($urandom_range(0, 15) == 0);
            d = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 3) == 0);
            step("rnd", t, w, d, a, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
